z16_decode_stage: RTL and testbench

Registered, handshaked instruction-decode stage for the Z16 core: decodes one 16-bit instruction per cycle into register addresses, sign-extended immediate and control strobes, and holds the result in a single pipeline register toward execute. Adds a load-use scoreboard that stalls fetch while a source or destination register awaits load writeback. Sits between the fetch buffer and the execute/register-read stage; the immediate width follows the datapath width.

---
 rtl/z16_decode_stage.sv | 150 +++++++++++++++
 tb/tb_z16_decode_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/z16_decode_stage.sv
// z16_decode_stage: Z16 instruction decode with one output pipeline register and load-use scoreboard.
// Rev 1.0
`default_nettype none

module z16_decode_stage #(
  parameter int DATA_W = 16,
  parameter bit SB_EN  = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_instr,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [3:0]        o_opcode,
  output logic [3:0]        o_rd_addr,
  output logic [3:0]        o_rs1_addr,
  output logic [3:0]        o_rs2_addr,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_rd_wen,
  output logic              o_mem_wen,
  output logic              o_is_load,
  output logic [3:0]        o_alu_ctrl,
  input  logic              i_wb_valid,
  input  logic [3:0]        i_wb_addr,
  output logic              o_hazard
);

  logic [3:0]        w_op, w_rd, w_rs1, w_rs2, w_alu;
  logic [DATA_W-1:0] w_imm;
  logic              w_rd_wen, w_mem_wen, w_is_load;
  logic              w_hazard, w_accept, w_issue;

  logic              valid_q, valid_d;
  logic [3:0]        op_q, rd_q, rs1_q, rs2_q, alu_q;
  logic [DATA_W-1:0] imm_q;
  logic              rd_wen_q, mem_wen_q, is_load_q;
  logic [15:0]       pend_q, pend_d;

  always_comb begin
    w_op      = i_instr[3:0];
    w_rd      = i_instr[7:4];
    w_rs1     = i_instr[11:8];
    w_rs2     = i_instr[15:12];
    w_imm     = '0;
    w_rd_wen  = 1'b1;
    w_mem_wen = 1'b0;
    w_is_load = 1'b0;
    w_alu     = (w_op <= 4'h8) ? w_op : 4'h0;
    case (w_op)
      4'h9: begin
        w_rs1 = i_instr[7:4];
        w_imm = {{(DATA_W-8){i_instr[15]}}, i_instr[15:8]};
      end
      4'hA: begin
        w_is_load = 1'b1;
        w_imm     = {{(DATA_W-4){i_instr[15]}}, i_instr[15:12]};
      end
      4'hB: begin
        w_rd_wen  = 1'b0;
        w_mem_wen = 1'b1;
        w_imm     = {{(DATA_W-4){i_instr[7]}}, i_instr[7:4]};
      end
      4'hC, 4'hD: w_imm = {{(DATA_W-4){i_instr[15]}}, i_instr[15:12]};
      4'hE, 4'hF: begin
        w_rd_wen = 1'b0;
        w_rs1    = {2'b00, i_instr[5:4]};
        w_rs2    = {2'b00, i_instr[7:6]};
        w_imm    = {{(DATA_W-8){i_instr[15]}}, i_instr[15:8]};
      end
      default: ;
    endcase
  end

  // Hazard uses the registered pending vector only; a writeback this cycle unblocks next cycle.
  assign w_hazard = SB_EN && i_instr_valid &&
                    (pend_q[w_rs1] || pend_q[w_rs2] || (w_rd_wen && pend_q[w_rd]));

  assign o_instr_ready = !i_flush && (!valid_q || i_ready) && !w_hazard;
  assign w_accept      = i_instr_valid && o_instr_ready;
  assign w_issue       = valid_q && i_ready;
  assign o_hazard      = w_hazard;

  always_comb begin
    valid_d = valid_q;
    if (w_accept)
      valid_d = 1'b1;
    else if (w_issue || i_flush)
      valid_d = 1'b0;
  end

  // Clears are applied first so that a load accepted this cycle keeps its pending bit.
  always_comb begin
    pend_d = pend_q;
    if (i_wb_valid)
      pend_d[i_wb_addr] = 1'b0;
    if (i_flush && valid_q && is_load_q)
      pend_d[rd_q] = 1'b0;
    if (w_accept && w_is_load)
      pend_d[w_rd] = 1'b1;
    if (!SB_EN)
      pend_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      alu_q     <= '0;
      imm_q     <= '0;
      rd_wen_q  <= 1'b0;
      mem_wen_q <= 1'b0;
      is_load_q <= 1'b0;
      pend_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
      if (w_accept) begin
        op_q      <= w_op;
        rd_q      <= w_rd;
        rs1_q     <= w_rs1;
        rs2_q     <= w_rs2;
        alu_q     <= w_alu;
        imm_q     <= w_imm;
        rd_wen_q  <= w_rd_wen;
        mem_wen_q <= w_mem_wen;
        is_load_q <= w_is_load;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_opcode   = op_q;
  assign o_rd_addr  = rd_q;
  assign o_rs1_addr = rs1_q;
  assign o_rs2_addr = rs2_q;
  assign o_imm      = imm_q;
  assign o_rd_wen   = rd_wen_q;
  assign o_mem_wen  = mem_wen_q;
  assign o_is_load  = is_load_q;
  assign o_alu_ctrl = alu_q;

endmodule

`default_nettype wire

// File: tb/tb_z16_decode_stage.sv
// tb_z16_decode_stage: directed bench with a decode reference model and an expected-output queue.
// Rev 1.0
`default_nettype none

module tb_z16_decode_stage;

  typedef struct packed {
    logic [3:0]  op, rd, rs1, rs2;
    logic [31:0] imm;
    logic        rdw, memw, ld;
    logic [3:0]  alu;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_instr;
  logic        i_instr_valid, i_flush, i_ready, i_wb_valid;
  logic [3:0]  i_wb_addr;

  logic        o_instr_ready, o_valid, o_rd_wen, o_mem_wen, o_is_load, o_hazard;
  logic [3:0]  o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_alu_ctrl;
  logic [31:0] o_imm;

  logic        n_instr_ready, n_valid, n_rd_wen, n_mem_wen, n_is_load, n_hazard;
  logic [3:0]  n_opcode, n_rd_addr, n_rs1_addr, n_rs2_addr, n_alu_ctrl;
  logic [15:0] n_imm;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  z16_decode_stage #(.DATA_W(32), .SB_EN(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(i_instr), .i_instr_valid(i_instr_valid),
    .o_instr_ready(o_instr_ready), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_opcode(o_opcode), .o_rd_addr(o_rd_addr), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_imm(o_imm), .o_rd_wen(o_rd_wen), .o_mem_wen(o_mem_wen), .o_is_load(o_is_load),
    .o_alu_ctrl(o_alu_ctrl), .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .o_hazard(o_hazard)
  );

  z16_decode_stage #(.DATA_W(16), .SB_EN(1'b0)) dut_nosb (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(i_instr), .i_instr_valid(i_instr_valid),
    .o_instr_ready(n_instr_ready), .i_flush(i_flush), .o_valid(n_valid), .i_ready(i_ready),
    .o_opcode(n_opcode), .o_rd_addr(n_rd_addr), .o_rs1_addr(n_rs1_addr), .o_rs2_addr(n_rs2_addr),
    .o_imm(n_imm), .o_rd_wen(n_rd_wen), .o_mem_wen(n_mem_wen), .o_is_load(n_is_load),
    .o_alu_ctrl(n_alu_ctrl), .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .o_hazard(n_hazard)
  );

  function automatic exp_t model(input logic [15:0] i);
    exp_t e;
    e.op  = i[3:0];
    e.rd  = i[7:4];
    e.rs1 = (e.op == 4'h9) ? i[7:4] : (e.op >= 4'hE) ? {2'b00, i[5:4]} : i[11:8];
    e.rs2 = (e.op >= 4'hE) ? {2'b00, i[7:6]} : i[15:12];
    case (e.op)
      4'h9, 4'hE, 4'hF: e.imm = {{24{i[15]}}, i[15:8]};
      4'hA, 4'hC, 4'hD: e.imm = {{28{i[15]}}, i[15:12]};
      4'hB:             e.imm = {{28{i[7]}}, i[7:4]};
      default:          e.imm = 32'h0;
    endcase
    e.rdw  = !(e.op == 4'hB || e.op == 4'hE || e.op == 4'hF);
    e.memw = (e.op == 4'hB);
    e.ld   = (e.op == 4'hA);
    e.alu  = (e.op < 4'h9) ? e.op : 4'h0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge: retire/compare issued outputs, queue accepted instructions.
  task automatic samp();
    exp_t e;
    @(negedge clk);
    if (i_flush && o_valid) begin
      if (q.size() > 0) q.delete(0);
    end else if (o_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_issue", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("opcode",  {28'h0, o_opcode},   {28'h0, e.op});
        chk("rd",      {28'h0, o_rd_addr},  {28'h0, e.rd});
        chk("rs1",     {28'h0, o_rs1_addr}, {28'h0, e.rs1});
        chk("rs2",     {28'h0, o_rs2_addr}, {28'h0, e.rs2});
        chk("imm",     o_imm,               e.imm);
        chk("rd_wen",  {31'h0, o_rd_wen},   {31'h0, e.rdw});
        chk("mem_wen", {31'h0, o_mem_wen},  {31'h0, e.memw});
        chk("is_load", {31'h0, o_is_load},  {31'h0, e.ld});
        chk("alu",     {28'h0, o_alu_ctrl}, {28'h0, e.alu});
      end
    end
    if (i_instr_valid && o_instr_ready) q.push_back(model(i_instr));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic rdy);
    i_instr_valid = v;
    i_instr       = ins;
    i_ready       = rdy;
  endtask

  initial begin
    rst_n = 1'b0; i_flush = 1'b0; i_wb_valid = 1'b0; i_wb_addr = 4'h0;
    drive(1'b0, 16'h0000, 1'b1);
    adv(); adv();
    rst_n = 1'b1;

    samp();
    chk("rst_valid", {31'h0, o_valid}, 32'd0);
    chk("rst_rd",    {28'h0, o_rd_addr}, 32'd0);
    chk("rst_imm",   o_imm, 32'd0);
    chk("rst_rdwen", {31'h0, o_rd_wen}, 32'd0);
    chk("rst_ready", {31'h0, o_instr_ready}, 32'd1);
    chk("rst_haz",   {31'h0, o_hazard}, 32'd0);
    adv();

    drive(1'b1, 16'h3210, 1'b1); samp(); adv();
    drive(1'b1, 16'hF859, 1'b1); samp();
    chk("lat1_valid", {31'h0, o_valid}, 32'd1);
    chk("op0_rd", {28'h0, o_rd_addr}, 32'd1);
    adv();
    drive(1'b1, 16'h12BB, 1'b1); samp();
    chk("op9_imm", o_imm, 32'hFFFF_FFF8);
    adv();
    drive(1'b0, 16'h0000, 1'b1); samp();
    chk("opB_imm16", {16'h0, n_imm}, 32'h0000_FFFB);
    chk("opB_imm32", o_imm, 32'hFFFF_FFFB);
    adv();

    // load-use stall
    drive(1'b1, 16'h014A, 1'b1); samp(); adv();
    drive(1'b1, 16'h0420, 1'b1);
    for (int k = 0; k < 2; k++) begin
      samp();
      chk("lu_haz",   {31'h0, o_hazard}, 32'd1);
      chk("lu_ready", {31'h0, o_instr_ready}, 32'd0);
      chk("nosb_haz", {31'h0, n_hazard}, 32'd0);
      chk("nosb_rdy", {31'h0, n_instr_ready}, 32'd1);
      adv();
    end
    i_wb_valid = 1'b1; i_wb_addr = 4'h4; samp();
    chk("lu_wb_nobypass", {31'h0, o_hazard}, 32'd1);
    adv();
    i_wb_valid = 1'b0; samp();
    chk("lu_after_wb_haz", {31'h0, o_hazard}, 32'd0);
    chk("lu_after_wb_rdy", {31'h0, o_instr_ready}, 32'd1);
    adv();
    drive(1'b0, 16'h0000, 1'b1); samp(); adv();

    // backpressure
    drive(1'b1, 16'h5675, 1'b0); samp(); adv();
    drive(1'b1, 16'h2346, 1'b0);
    for (int k = 0; k < 3; k++) begin
      samp();
      chk("bp_valid", {31'h0, o_valid}, 32'd1);
      chk("bp_rd",    {28'h0, o_rd_addr}, 32'd7);
      chk("bp_alu",   {28'h0, o_alu_ctrl}, 32'd5);
      chk("bp_ready", {31'h0, o_instr_ready}, 32'd0);
      adv();
    end
    i_ready = 1'b1; samp();
    chk("bp_release_rdy", {31'h0, o_instr_ready}, 32'd1);
    adv();
    drive(1'b0, 16'h0000, 1'b1); samp();
    chk("bp_second_alu", {28'h0, o_alu_ctrl}, 32'd6);
    adv();

    // flush held load
    drive(1'b1, 16'h003A, 1'b0); samp(); adv();
    drive(1'b0, 16'h0000, 1'b0); i_flush = 1'b1; samp();
    chk("fl_ready", {31'h0, o_instr_ready}, 32'd0);
    adv();
    i_flush = 1'b0; drive(1'b1, 16'h0350, 1'b1); samp();
    chk("fl_valid", {31'h0, o_valid}, 32'd0);
    chk("fl_haz",   {31'h0, o_hazard}, 32'd0);
    chk("fl_rdy",   {31'h0, o_instr_ready}, 32'd1);
    adv();
    drive(1'b0, 16'h0000, 1'b1); samp(); adv();

    // same-cycle wb and load accept on the same register: set wins
    drive(1'b1, 16'h004A, 1'b1); i_wb_valid = 1'b1; i_wb_addr = 4'h4; samp();
    chk("sw_accept_rdy", {31'h0, o_instr_ready}, 32'd1);
    adv();
    i_wb_valid = 1'b0; drive(1'b1, 16'h0420, 1'b1); samp();
    chk("sw_set_wins", {31'h0, o_hazard}, 32'd1);
    adv();
    drive(1'b0, 16'h0000, 1'b1); i_wb_valid = 1'b1; samp(); adv();
    i_wb_valid = 1'b0; drive(1'b1, 16'h0420, 1'b1); samp();
    chk("sw_clear_haz", {31'h0, o_hazard}, 32'd0);
    adv();
    drive(1'b0, 16'h0000, 1'b1); samp(); adv();

    // asynchronous reset mid-operation
    drive(1'b1, 16'h003A, 1'b0); samp(); adv();
    drive(1'b0, 16'h0000, 1'b0); rst_n = 1'b0; #1;
    chk("ar_valid", {31'h0, o_valid}, 32'd0);
    chk("ar_rd",    {28'h0, o_rd_addr}, 32'd0);
    chk("ar_load",  {31'h0, o_is_load}, 32'd0);
    q.delete();
    samp(); adv();
    rst_n = 1'b1;
    drive(1'b1, 16'h0350, 1'b1); samp();
    chk("ar_pend_clr", {31'h0, o_hazard}, 32'd0);
    chk("ar_rdy",      {31'h0, o_instr_ready}, 32'd1);
    adv();
    drive(1'b0, 16'h0000, 1'b1); samp(); adv();

    chk("sb_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
